// File: rtl/nnrv_pkg.sv
// nnrv_lsu shared encodings and lane helpers.
// Build option: NNRV_LSU_MISALIGN_TRAP_EN (see nnrv_lsu.sv).
package nnrv_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  // A double on a 32-bit datapath degrades to a word.
  function automatic logic [1:0] eff_size(
    input logic [1:0] sz,
    input int         xlen
  );
    return (xlen == 32 && sz == SZ_D) ? SZ_W : sz;
  endfunction

  function automatic logic [3:0] size_bytes(
    input logic [1:0] sz
  );
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/nnrv_lsu_align.sv
// Byte-lane alignment: store mask/data placement or
// load extraction with sign/zero extension (LOAD=1).
module nnrv_lsu_align
  import nnrv_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  bit LOAD = 1'b0,
  localparam int NB   = XLEN / 8,
  localparam int OFS  = $clog2(NB)
) (
  input  logic [1:0]      i_size,
  input  logic [OFS-1:0]  i_ofs,
  input  logic            i_sign,
  input  logic [XLEN-1:0] i_data,
  output logic [NB-1:0]   o_mask,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shl;
  logic [XLEN-1:0] w_shr;
  logic [XLEN-1:0] w_fmt;
  logic            w_msb;
  logic            w_fill;
  int              w_nb;

  always_comb begin
    w_nb  = int'(size_bytes(i_size));
    w_shl = i_data << {i_ofs, 3'b000};
    w_shr = i_data >> {i_ofs, 3'b000};
    for (int i = 0; i < NB; i++) begin
      o_mask[i] = (i >= int'(i_ofs)) &&
                  (i < int'(i_ofs) + w_nb);
    end
    case (i_size)
      SZ_B:    w_msb = w_shr[7];
      SZ_H:    w_msb = w_shr[15];
      SZ_W:    w_msb = w_shr[31];
      default: w_msb = w_shr[XLEN-1];
    endcase
    w_fill = i_sign & w_msb;
    for (int i = 0; i < XLEN; i++) begin
      w_fmt[i] = (i < 8 * w_nb) ? w_shr[i] : w_fill;
    end
    o_data = LOAD ? w_fmt : w_shl;
  end

endmodule

// File: rtl/nnrv_lsu.sv
// Load/store unit with req/gnt/rvalid memory port.
// Build option: NNRV_LSU_MISALIGN_TRAP_EN traps misaligned ops.
module nnrv_lsu
  import nnrv_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFS  = $clog2(NB)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_exec_valid,
  output logic            o_exec_ready,
  input  logic            i_exec_rd_en,
  input  logic [4:0]      i_exec_rd,
  input  logic [XLEN-1:0] i_exec_rd_reg,
  input  logic            i_exec_ram_rd_en,
  input  logic            i_exec_ram_wr_en,
  input  logic [XLEN-1:0] i_exec_ram_addr,
  input  logic [XLEN-1:0] i_exec_ram_data,
  input  logic [1:0]      i_exec_size,
  input  logic            i_exec_sign,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [NB-1:0]   o_mem_wmask,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_wb_valid,
  output logic            o_wb_rd_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_rd_reg,
  output logic            o_id_rd_en,
  output logic            o_id_rd_ready,
  output logic [4:0]      o_id_rd,
  output logic [XLEN-1:0] o_id_rd_reg,
  output logic            o_exc_misalign,
  output logic [XLEN-1:0] o_exc_addr
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;

  logic              r_rd_en;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_rd_reg;
  logic              r_ld;
  logic              r_st;
  logic [XLEN-1:OFS] r_addr_hi;
  logic [OFS-1:0]    r_ofs;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [XLEN-1:0]   r_data;

  logic              r_wb_valid;
  logic              r_wb_rd_en;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_rd_reg;

  logic              w_accept;
  logic              w_mem;
  logic              w_issue;
  logic [1:0]        w_size;
  logic [OFS-1:0]    w_lo;
  logic [OFS-1:0]    w_ofs;
  logic              w_req;
  logic              w_ld_wait;
  logic [NB-1:0]     w_st_mask;
  logic [NB-1:0]     w_ld_mask;
  logic [XLEN-1:0]   w_st_data;
  logic [XLEN-1:0]   w_ld_data;

  assign w_accept = i_exec_valid & o_exec_ready;
  assign w_mem    = i_exec_ram_rd_en |
                    i_exec_ram_wr_en;
  assign w_size   = eff_size(i_exec_size, XLEN);
  assign w_lo     = OFS'(size_bytes(w_size) - 4'd1);

`ifdef NNRV_LSU_MISALIGN_TRAP_EN
  logic            w_mis;
  logic            r_exc;
  logic [XLEN-1:0] r_exc_addr;

  assign w_mis   = (i_exec_ram_addr[OFS-1:0] & w_lo) != '0;
  assign w_ofs   = i_exec_ram_addr[OFS-1:0];
  assign w_issue = w_accept & w_mem & ~w_mis;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
    end else begin
      r_exc <= w_accept & w_mem & w_mis;
      if (w_accept && w_mem && w_mis) begin
        r_exc_addr <= i_exec_ram_addr;
      end
    end
  end

  assign o_exc_misalign = r_exc;
  assign o_exc_addr     = r_exc_addr;
`else
  // Misaligned addresses are silently aligned down to the size.
  assign w_ofs   = i_exec_ram_addr[OFS-1:0] & ~w_lo;
  assign w_issue = w_accept & w_mem;

  assign o_exc_misalign = 1'b0;
  assign o_exc_addr     = '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_issue) w_next = ST_REQ;
      ST_REQ: begin
        if (i_mem_gnt) begin
          w_next = r_st ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: if (i_mem_rvalid) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_en   <= 1'b0;
      r_rd      <= '0;
      r_rd_reg  <= '0;
      r_ld      <= 1'b0;
      r_st      <= 1'b0;
      r_addr_hi <= '0;
      r_ofs     <= '0;
      r_size    <= '0;
      r_sign    <= 1'b0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_rd_en   <= i_exec_rd_en;
      r_rd      <= i_exec_rd;
      r_rd_reg  <= i_exec_rd_reg;
      r_ld      <= i_exec_ram_rd_en;
      r_st      <= i_exec_ram_wr_en;
      r_addr_hi <= i_exec_ram_addr[XLEN-1:OFS];
      r_ofs     <= w_ofs;
      r_size    <= w_size;
      r_sign    <= i_exec_sign;
      r_data    <= i_exec_ram_data;
    end
  end

  nnrv_lsu_align #(.XLEN(XLEN), .LOAD(1'b0)) u_st (
    .i_size (r_size),
    .i_ofs  (r_ofs),
    .i_sign (r_sign),
    .i_data (r_data),
    .o_mask (w_st_mask),
    .o_data (w_st_data)
  );

  nnrv_lsu_align #(.XLEN(XLEN), .LOAD(1'b1)) u_ld (
    .i_size (r_size),
    .i_ofs  (r_ofs),
    .i_sign (r_sign),
    .i_data (i_mem_rdata),
    .o_mask (w_ld_mask),
    .o_data (w_ld_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wb_valid  <= 1'b0;
      r_wb_rd_en  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_rd_reg <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept && !w_issue) begin
        r_wb_valid  <= 1'b1;
        r_wb_rd_en  <= i_exec_rd_en & ~w_mem;
        r_wb_rd     <= i_exec_rd;
        r_wb_rd_reg <= i_exec_rd_reg;
      end else if (r_state == ST_REQ && i_mem_gnt && r_st) begin
        r_wb_valid  <= 1'b1;
        r_wb_rd_en  <= 1'b0;
        r_wb_rd     <= r_rd;
        r_wb_rd_reg <= r_rd_reg;
      end else if (r_state == ST_RESP && i_mem_rvalid) begin
        r_wb_valid  <= 1'b1;
        r_wb_rd_en  <= r_rd_en;
        r_wb_rd     <= r_rd;
        r_wb_rd_reg <= w_ld_data;
      end
    end
  end

  always_comb begin
    w_req         = (r_state == ST_REQ);
    w_ld_wait     = (r_state != ST_IDLE) & r_ld;
    o_exec_ready  = (r_state == ST_IDLE);
    o_mem_req     = w_req;
    o_mem_we      = w_req & r_st;
    o_mem_addr    = w_req ? {r_addr_hi, OFS'(0)} : '0;
    o_mem_wmask   = '0;
    if (w_req) begin
      o_mem_wmask = r_st ? w_st_mask : w_ld_mask;
    end
    o_mem_wdata   = (w_req & r_st) ? w_st_data : '0;
    o_wb_valid    = r_wb_valid;
    o_wb_rd_en    = r_wb_rd_en;
    o_wb_rd       = r_wb_rd;
    o_wb_rd_reg   = r_wb_rd_reg;
    // A load in flight blocks decode from using its destination.
    o_id_rd_en    = w_ld_wait | r_wb_rd_en;
    o_id_rd_ready = ~w_ld_wait & r_wb_rd_en;
    o_id_rd       = w_ld_wait ? r_rd : r_wb_rd;
    o_id_rd_reg   = r_wb_rd_reg;
  end

endmodule

// File: doc/nnrv_lsu.md
# nnrv_lsu

Parametrised load/store unit that replaces the fixed single-cycle memory stage between execute and write-back. It accepts one operation at a time from execute. It drives a variable-latency request/grant/response memory port with byte-lane-aligned stores and sign/zero-extended loads. It stalls execute while an access is outstanding and forwards the pending or completed destination to decode.

## Interface
- XLEN, 32, data width; 32 or 64
- NB, XLEN/8, byte lanes (derived, not overridable)
- OFS, $clog2(NB), address offset bits (derived)
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_exec_valid  in  1  operation presented
- o_exec_ready  out  1  unit accepts operation this cycle
- i_exec_rd_en / i_exec_rd / i_exec_rd_reg  in  1/5/XLEN  destination enable, index, ALU result
- i_exec_ram_rd_en / i_exec_ram_wr_en  in  1/1  load / store (mutually exclusive)
- i_exec_ram_addr / i_exec_ram_data  in  XLEN/XLEN  byte address, store data (LSB-justified)
- i_exec_size  in  2  0 byte, 1 half, 2 word, 3 double (XLEN=64 only)
- i_exec_sign  in  1  sign-extend load
- o_mem_req / o_mem_we  out  1/1  request, write
- o_mem_addr  out  XLEN  address with low OFS bits zero
- o_mem_wmask / o_mem_wdata  out  NB/XLEN  lane mask, lane-aligned data
- i_mem_gnt  in  1  request accepted
- i_mem_rvalid / i_mem_rdata  in  1/XLEN  load response
- o_wb_valid / o_wb_rd_en / o_wb_rd / o_wb_rd_reg  out  1/1/5/XLEN  retire pulse and result
- o_id_rd_en / o_id_rd_ready / o_id_rd / o_id_rd_reg  out  1/1/5/XLEN  decode forwarding
- o_exc_misalign / o_exc_addr  out  1/XLEN  misaligned access pulse, faulting address

## Operation
- States: IDLE, REQ, RESP. Reset → IDLE. o_exec_ready = (state==IDLE).
- Accept = i_exec_valid & o_exec_ready. All fields captured into the stage register.
- Non-memory op: stays IDLE; next cycle o_wb_valid=1 with captured rd_en/rd/rd_reg.
- Memory op, aligned: → REQ. o_mem_req=1 held with stable fields until i_mem_gnt.
- Store granted: → IDLE, o_wb_valid=1 next cycle with rd_en=0.
- Load granted: → RESP. i_mem_rvalid is sampled only in RESP. On rvalid, data is formatted, → IDLE, and o_wb_valid=1 next cycle.
- Store lanes: wmask = ((1<<2^size)-1) << ofs. wdata = data << (8·ofs), with unused lanes don't-care.
- Load format: rdata >> (8·ofs), truncated to 8·2^size bits, then sign-extended if i_exec_sign, else zero-extended. Double ignores sign.
- Misaligned means ofs is not a multiple of 2^size. Handling is set by configuration.
- Forwarding: the o_id_* outputs equal the o_wb_* values, except in REQ/RESP for a load, where o_id_rd_en=1, o_id_rd=load rd, o_id_rd_ready=0.
- o_wb_* and o_exc_* are registered. o_mem_* is decoded from state plus the stage register.

## Timing
- Reset values: all outputs 0 except o_exec_ready=1. State IDLE. Stage register cleared.
- Latency accept→o_wb_valid: non-memory op 1 cycle. Store 1+g cycles (g ≥ 1 cycles in REQ). Load 1+g+r cycles (r ≥ 1 cycles in RESP).
- o_wb_valid is a single-cycle pulse. Back-to-back non-memory ops retire every cycle.
- o_mem_req is never asserted in IDLE. Request fields must not change while req=1 and gnt=0.
- i_mem_rvalid in IDLE or REQ is ignored. No outstanding-request counter is kept.
- Reset mid-operation: req drops asynchronously, any in-flight op is discarded, and no o_wb_valid is produced. The memory must tolerate an abandoned request.
- Size 3 with XLEN=32 is treated as size 2.

## Configuration
- NNRV_LSU_MISALIGN_TRAP_EN defined: a misaligned op is not issued and stays IDLE. Next cycle o_exc_misalign=1, o_exc_addr=address, o_wb_valid=1 with rd_en=0.
- Undefined: the address is aligned down to size (ofs &= ~(2^size-1)) and the access proceeds normally. o_exc_misalign and o_exc_addr are tied 0.

## Structure
- Package nnrv_pkg holds the size encodings (SZ_B/H/W/D), the state encodings (ST_IDLE/REQ/RESP), and the XLEN-derived lane helpers.
- Sub-module nnrv_lsu_align: purely combinational. It produces store lane mask/data and formats load data from size/ofs/sign. It is instantiated once for each direction.

## Test plan
- XLEN=32, non-memory op rd=5, rd_reg=0x1234 → o_wb_valid next cycle, o_wb_rd=5, o_wb_rd_reg=0x1234, o_exec_ready stays 1.
- Store byte 0xAB at addr 0x1003, gnt after 2 cycles → o_mem_addr=0x1000, wmask=4'b1000, wdata[31:24]=0xAB, req held 2 cycles, o_exec_ready=0 until retire.
- Load half, signed, addr 0x2002, rdata=0x8001_0000, rvalid 3 cycles after gnt → o_wb_rd_reg=0xFFFF_8001. o_id_rd_ready=0 during the wait, with o_id_rd equal to the load rd.
- Same load unsigned → 0x0000_8001. Load byte addr 0x2001 with rdata=0x0000_7F00 → 0x0000_007F.
- Word load at 0x3002: with the macro → o_exc_misalign=1, o_exc_addr=0x3002, no o_mem_req. Without the macro → o_mem_addr=0x3000, wmask 4'b1111.
- Assert i_rst while in RESP → o_mem_req=0 immediately, state IDLE. A late i_mem_rvalid produces no o_wb_valid. XLEN=64 double store at 0x8 → wmask 8'hFF.
